prbs31_bert_ctrl: RTL and testbench
===================================

Name: prbs31_bert_ctrl

Overview:
Bit-error-rate test controller for the PRBS31 (x^31 + x^28 + 1) pattern path. Sequences an external PRBS31 generator (seed load, run enable) and contains the receive-side checker: acquires lock on the incoming serial stream, checks a programmed number of bits, counts errors, detects loss of lock with automatic resync, and reports pass/fail. Sits between the pad-level pattern generator and the user-facing control/status pins.

Parameters:
LEN_W, 16, width of test_len and bit_cnt
ERR_W, 16, width of err_cnt (saturating)
WIN, 64, loss-of-lock observation window in checked bits
LOL_THR, 8, errors within one window that declare loss of lock

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock, reset is synchronous and active-high (the port keeps the codebase name rst_n although it is active-high)
start  input  1  begin a test (sampled only in IDLE)
abort  input  1  cancel the running test
test_len  input  LEN_W  number of bits to check; captured on accepted start
rx_bit  input  1  received serial bit
rx_valid  input  1  rx_bit qualifier, one bit per cycle max
gen_load  output  1  one-cycle pulse: generator loads seed 31'b1
gen_en  output  1  generator advance enable
busy  output  1  high in any state except IDLE
locked  output  1  high in CHECK
done  output  1  one-cycle pulse on normal completion
pass  output  1  last test: err_cnt==0 and resync_cnt==0
err_cnt  output  ERR_W  mismatches in last/current test
resync_cnt  output  8  loss-of-lock events, saturating at 255
bit_cnt  output  LEN_W  checked bits in current test

Behaviour:
- Reset (rst_n=1 at posedge): state IDLE; chk register, all counters 0; gen_load, gen_en, busy, locked, done, pass = 0.
- States: IDLE, SEED, SYNC, CHECK, DONE.
- IDLE: start=1 -> SEED next cycle; capture test_len into len_q; clear err_cnt, resync_cnt, bit_cnt, pass. start outside IDLE ignored.
- SEED: exactly one cycle; gen_load=1, gen_en=0 -> SYNC.
- SYNC: gen_en=1. Each rx_valid cycle shifts rx_bit into chk[0], chk[30:1]<=chk[29:0]; fill counter +1. When 31st bit is shifted: if resulting chk value is all zero, fill counter clears and SYNC continues (lock-up state rejected); else -> CHECK. If len_q==0, go to DONE instead of CHECK.
- CHECK: gen_en=1, locked=1. Per rx_valid: exp = chk[27]^chk[30]; mismatch (rx_bit!=exp) -> err_cnt+1 (saturate at all ones) and window error count+1. chk shifts in exp (not rx_bit), so one flipped bit counts one error. bit_cnt+1 per checked bit; window bit counter+1, clears with window error count every WIN bits.
- Loss of lock: window error count reaching LOL_THR -> SYNC next cycle, resync_cnt+1 (sat), fill counter cleared; bit_cnt and err_cnt retained, not reset.
- Completion: the checked bit that makes bit_cnt==len_q -> DONE next cycle (takes priority over loss-of-lock on the same bit).
- DONE: one cycle; done=1, pass computed; -> IDLE. Results held until next accepted start.
- rx_valid=0: no shift, no count, no state change in SYNC/CHECK.
- abort=1 in SEED/SYNC/CHECK/DONE -> IDLE next cycle; no done pulse; pass=0; counters frozen. abort priority over every other transition; rst_n priority over abort.
- Latency: start at cycle N -> gen_load at N+1 -> gen_en from N+2.

Test Plan:
- Clean PRBS31 stream from seed 1, test_len=100, rx_valid always 1 -> locked after 31 bits; done pulse after 131 valid bits + pipeline; pass=1, err_cnt=0, resync_cnt=0, bit_cnt=100.
- Same, flip checked bit 10 -> err_cnt=1, pass=0, locked never drops, resync_cnt=0.
- Flip 8 bits within first 64 checked bits, test_len=500 -> locked falls, SYNC re-entered, relock after 31 bits, resync_cnt=1, err_cnt=8, pass=0, done asserted.
- rx_bit held 0 for 100 valid cycles -> stays in SYNC, locked=0; then abort=1 -> IDLE next cycle, busy=0, no done.
- rx_valid toggled 1/0 with clean stream, test_len=40 -> identical results to continuous case; reset asserted mid-CHECK -> all outputs at reset values next cycle.
- ERR_W=4, inverted stream after lock, test_len=50 -> err_cnt saturates at 15; test_len=0 -> done right after sync, pass=1, bit_cnt=0.

Source files
------------

// File: rtl/prbs31_bert_ctrl.sv
// PRBS31 (x^31 + x^28 + 1) bit-error-rate test controller: sequences an external
// generator and checks the returned serial stream with lock, loss-of-lock resync and error counting.
module prbs31_bert_ctrl #(
  parameter int LEN_W   = 16,
  parameter int ERR_W   = 16,
  parameter int WIN     = 64,
  parameter int LOL_THR = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] test_len,
  input  logic             rx_bit,
  input  logic             rx_valid,
  output logic             gen_load,
  output logic             gen_en,
  output logic             busy,
  output logic             locked,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       resync_cnt,
  output logic [LEN_W-1:0] bit_cnt
);
  localparam int WB = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int WE = $clog2(LOL_THR + 1);

  typedef enum logic [2:0] {IDLE, SEED, SYNC, CHECK, DONE} state_t;

  state_t           state, state_nxt;
  logic [30:0]      chk;
  logic [4:0]       fill;
  logic [LEN_W-1:0] len_q;
  logic [WB-1:0]    win_bits;
  logic [WE-1:0]    win_err;

  logic             exp_bit, mism, fill_full, last_bit, lol;
  logic [30:0]      chk_sync;
  logic [LEN_W-1:0] bit_nxt;
  logic [WE-1:0]    win_err_nxt;

  assign exp_bit     = chk[27] ^ chk[30];
  assign mism        = rx_bit ^ exp_bit;
  assign chk_sync    = {chk[29:0], rx_bit};
  assign fill_full   = (fill == 5'd30);
  assign bit_nxt     = bit_cnt + 1'b1;
  assign last_bit    = (bit_nxt == len_q);
  assign win_err_nxt = win_err + WE'(mism);
  assign lol         = (win_err_nxt == WE'(LOL_THR));

  assign gen_load = (state == SEED);
  assign gen_en   = (state == SYNC) || (state == CHECK);
  assign busy     = (state != IDLE);
  assign locked   = (state == CHECK);
  assign done     = (state == DONE) && !abort;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = SEED;
      SEED:  state_nxt = SYNC;
      // an all-zero window is the LFSR lock-up state and never qualifies as lock
      SYNC:  if (rx_valid && fill_full && (chk_sync != 31'd0))
               state_nxt = (len_q == '0) ? DONE : CHECK;
      CHECK: if (rx_valid) begin
               if (last_bit) state_nxt = DONE;
               else if (lol) state_nxt = SYNC;
             end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      chk        <= '0;
      fill       <= '0;
      len_q      <= '0;
      win_bits   <= '0;
      win_err    <= '0;
      err_cnt    <= '0;
      resync_cnt <= '0;
      bit_cnt    <= '0;
      pass       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          len_q      <= test_len;
          err_cnt    <= '0;
          resync_cnt <= '0;
          bit_cnt    <= '0;
          pass       <= 1'b0;
          fill       <= '0;
        end
        SYNC: begin
          win_bits <= '0;
          win_err  <= '0;
          if (!abort && rx_valid) begin
            chk  <= chk_sync;
            fill <= fill_full ? 5'd0 : fill + 5'd1;
          end
        end
        CHECK: if (!abort && rx_valid) begin
          // reference advances on the predicted bit so one flipped bit costs one error
          chk     <= {chk[29:0], exp_bit};
          bit_cnt <= bit_nxt;
          if (mism && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          if (win_bits == WB'(WIN - 1)) begin
            win_bits <= '0;
            win_err  <= '0;
          end else begin
            win_bits <= win_bits + 1'b1;
            win_err  <= win_err_nxt;
          end
          if (lol && !last_bit) begin
            fill <= '0;
            if (resync_cnt != 8'hFF) resync_cnt <= resync_cnt + 8'd1;
          end
        end
        DONE: pass <= !abort && (err_cnt == '0) && (resync_cnt == 8'd0);
        default: ;
      endcase
      if (abort && state != IDLE) pass <= 1'b0;
    end
  end
endmodule

// File: tb/tb_prbs31_bert_ctrl.sv
// Directed bench for prbs31_bert_ctrl: clean, errored, loss-of-lock, abort, gapped,
// reset, saturation and zero-length tests against a reference PRBS31 stream.
module tb_prbs31_bert_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, abort = 1'b0, rx_bit = 1'b0, rx_valid = 1'b0;
  logic [15:0] test_len = '0;
  logic        gen_load, gen_en, busy, locked, done, pass;
  logic [15:0] err_cnt, bit_cnt;
  logic [7:0]  resync_cnt;
  logic        gen_load4, gen_en4, busy4, locked4, done4, pass4;
  logic [3:0]  err_cnt4;
  logic [15:0] bit_cnt4;
  logic [7:0]  resync_cnt4;

  prbs31_bert_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .test_len(test_len),
    .rx_bit(rx_bit), .rx_valid(rx_valid), .gen_load(gen_load), .gen_en(gen_en),
    .busy(busy), .locked(locked), .done(done), .pass(pass), .err_cnt(err_cnt),
    .resync_cnt(resync_cnt), .bit_cnt(bit_cnt));

  prbs31_bert_ctrl #(.ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .test_len(test_len),
    .rx_bit(rx_bit), .rx_valid(rx_valid), .gen_load(gen_load4), .gen_en(gen_en4),
    .busy(busy4), .locked(locked4), .done(done4), .pass(pass4), .err_cnt(err_cnt4),
    .resync_cnt(resync_cnt4), .bit_cnt(bit_cnt4));

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;
  bit prbs [0:1023];
  int lock_k, relock_k, done_k;
  bit lost, gl1, ge1, ge2, done_after, busy_after;

  task automatic do_start(input int len);
    test_len = 16'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    gl1 = gen_load; ge1 = gen_en;
    @(posedge clk); #1;
    ge2 = gen_en;
  endtask

  // streams reference bits (optionally flipped/inverted/zeroed/gapped) until done or stop_n bits
  task automatic stream(input int stop_n, input int flo, input int fhi, input bit inv,
                        input bit zero, input bit tog, input int max_cyc);
    int k = 0, cyc = 0;
    bit v, b;
    lock_k = -1; relock_k = -1; done_k = -1; lost = 0;
    while (cyc < max_cyc && done_k < 0 && !(stop_n > 0 && k >= stop_n)) begin
      v = tog ? (cyc % 2 == 0) : 1'b1;
      b = prbs[k];
      if (k >= flo && k <= fhi) b = ~b;
      if (inv && k >= 31) b = ~b;
      if (zero) b = 1'b0;
      rx_valid = v; rx_bit = b;
      @(posedge clk); #1;
      if (v) k++;
      cyc++;
      if (locked) begin
        if (lock_k < 0) lock_k = k;
        else if (lost && relock_k < 0) relock_k = k;
      end else if (busy && !done && lock_k >= 0) lost = 1;
      if (done) done_k = k;
    end
    rx_valid = 1'b0;
    if (done_k >= 0) begin
      @(posedge clk); #1;
      done_after = done; busy_after = busy;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if ({gen_load, gen_en, busy, locked, done, pass} !== 6'b0) begin errs++; $display("FAIL reset_flags got %b want 000000", {gen_load, gen_en, busy, locked, done, pass}); end
    vecs++; if ({err_cnt, resync_cnt, bit_cnt} !== 40'd0) begin errs++; $display("FAIL reset_counts got %h want 0", {err_cnt, resync_cnt, bit_cnt}); end
    rst_n = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean;
    do_start(100);
    vecs++; if (gl1 !== 1'b1 || ge1 !== 1'b0) begin errs++; $display("FAIL seed_cycle got load=%b en=%b want 1 0", gl1, ge1); end
    vecs++; if (ge2 !== 1'b1) begin errs++; $display("FAIL gen_en_latency got %b want 1", ge2); end
    stream(0, -1, -1, 0, 0, 0, 400);
    vecs++; if (lock_k != 31) begin errs++; $display("FAIL clean_lock got %0d want 31", lock_k); end
    vecs++; if (done_k != 131) begin errs++; $display("FAIL clean_done got %0d want 131", done_k); end
    vecs++; if (done_after !== 1'b0 || busy_after !== 1'b0) begin errs++; $display("FAIL clean_done_pulse got done=%b busy=%b want 0 0", done_after, busy_after); end
    vecs++; if (pass !== 1'b1 || err_cnt !== 16'd0 || resync_cnt !== 8'd0) begin errs++; $display("FAIL clean_result got pass=%b err=%0d rs=%0d want 1 0 0", pass, err_cnt, resync_cnt); end
    vecs++; if (bit_cnt !== 16'd100) begin errs++; $display("FAIL clean_bits got %0d want 100", bit_cnt); end
  endtask

  task automatic test_single_err;
    do_start(100);
    stream(0, 41, 41, 0, 0, 0, 400);
    vecs++; if (err_cnt !== 16'd1 || pass !== 1'b0) begin errs++; $display("FAIL single_err got err=%0d pass=%b want 1 0", err_cnt, pass); end
    vecs++; if (lost !== 1'b0 || resync_cnt !== 8'd0) begin errs++; $display("FAIL single_lock got lost=%b rs=%0d want 0 0", lost, resync_cnt); end
    vecs++; if (done_k != 131) begin errs++; $display("FAIL single_done got %0d want 131", done_k); end
  endtask

  task automatic test_lol;
    do_start(500);
    stream(0, 40, 47, 0, 0, 0, 1000);
    vecs++; if (lost !== 1'b1 || relock_k != 79) begin errs++; $display("FAIL lol_relock got lost=%b relock=%0d want 1 79", lost, relock_k); end
    vecs++; if (resync_cnt !== 8'd1 || err_cnt !== 16'd8) begin errs++; $display("FAIL lol_counts got rs=%0d err=%0d want 1 8", resync_cnt, err_cnt); end
    vecs++; if (done_k != 562 || bit_cnt !== 16'd500 || pass !== 1'b0) begin errs++; $display("FAIL lol_done got k=%0d bits=%0d pass=%b want 562 500 0", done_k, bit_cnt, pass); end
  endtask

  task automatic test_abort;
    do_start(100);
    stream(100, -1, -1, 0, 1, 0, 300);
    vecs++; if (lock_k != -1 || locked !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL zero_sync got lock=%0d locked=%b busy=%b want -1 0 1", lock_k, locked, busy); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    vecs++; if (busy !== 1'b0 || done !== 1'b0 || gen_en !== 1'b0) begin errs++; $display("FAIL abort_idle got busy=%b done=%b en=%b want 0 0 0", busy, done, gen_en); end
    @(posedge clk); #1;
    vecs++; if (done !== 1'b0 || pass !== 1'b0) begin errs++; $display("FAIL abort_nodone got done=%b pass=%b want 0 0", done, pass); end
  endtask

  task automatic test_toggle;
    do_start(40);
    stream(0, -1, -1, 0, 0, 1, 400);
    vecs++; if (lock_k != 31 || done_k != 71) begin errs++; $display("FAIL gap_timing got lock=%0d done=%0d want 31 71", lock_k, done_k); end
    vecs++; if (pass !== 1'b1 || err_cnt !== 16'd0 || bit_cnt !== 16'd40) begin errs++; $display("FAIL gap_result got pass=%b err=%0d bits=%0d want 1 0 40", pass, err_cnt, bit_cnt); end
  endtask

  task automatic test_reset_mid;
    do_start(100);
    stream(50, 45, 45, 0, 0, 0, 200);
    vecs++; if (locked !== 1'b1 || bit_cnt !== 16'd19 || err_cnt !== 16'd1) begin errs++; $display("FAIL mid_check got locked=%b bits=%0d err=%0d want 1 19 1", locked, bit_cnt, err_cnt); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    vecs++; if ({gen_load, gen_en, busy, locked, done, pass} !== 6'b0) begin errs++; $display("FAIL mid_reset_flags got %b want 000000", {gen_load, gen_en, busy, locked, done, pass}); end
    vecs++; if ({err_cnt, resync_cnt, bit_cnt} !== 40'd0) begin errs++; $display("FAIL mid_reset_counts got %h want 0", {err_cnt, resync_cnt, bit_cnt}); end
  endtask

  task automatic test_saturate;
    do_start(50);
    stream(0, -1, -1, 1, 0, 0, 600);
    vecs++; if (err_cnt4 !== 4'd15) begin errs++; $display("FAIL sat_err4 got %0d want 15", err_cnt4); end
    vecs++; if (err_cnt !== 16'd50 || resync_cnt !== 8'd6) begin errs++; $display("FAIL inv_counts got err=%0d rs=%0d want 50 6", err_cnt, resync_cnt); end
    vecs++; if (done_k != 267 || bit_cnt !== 16'd50 || pass !== 1'b0) begin errs++; $display("FAIL inv_done got k=%0d bits=%0d pass=%b want 267 50 0", done_k, bit_cnt, pass); end
  endtask

  task automatic test_zero_len;
    do_start(0);
    stream(0, -1, -1, 0, 0, 0, 200);
    vecs++; if (done_k != 31 || lock_k != -1) begin errs++; $display("FAIL zlen_done got done=%0d lock=%0d want 31 -1", done_k, lock_k); end
    vecs++; if (pass !== 1'b1 || bit_cnt !== 16'd0 || err_cnt !== 16'd0) begin errs++; $display("FAIL zlen_result got pass=%b bits=%0d err=%0d want 1 0 0", pass, bit_cnt, err_cnt); end
  endtask

  initial begin
    logic [30:0] g;
    g = 31'd1;
    for (int i = 0; i < 1024; i++) begin
      prbs[i] = g[27] ^ g[30];
      g = {g[29:0], prbs[i]};
    end
    test_reset;
    test_clean;
    test_single_err;
    test_lol;
    test_abort;
    test_toggle;
    test_reset_mid;
    test_saturate;
    test_zero_len;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
